// File: rtl/uart_ctrl_fifo_pkg.sv
// Shared register map, bit positions and TX launcher state encodings for uart_ctrl_fifo.
package uart_ctrl_fifo_pkg;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_LEVEL  = 2'd3;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    localparam int ST_IRQ_RX   = 0;
    localparam int ST_IRQ_TX   = 1;
    localparam int ST_RX_BUSY  = 2;
    localparam int ST_TX_BUSY  = 3;
    localparam int ST_RX_EMPTY = 4;
    localparam int ST_TX_FULL  = 5;
    localparam int ST_RX_OVF   = 6;

    localparam logic [1:0] TX_IDLE   = 2'd0;
    localparam logic [1:0] TX_LAUNCH = 2'd1;
    localparam logic [1:0] TX_WAIT   = 2'd2;

    typedef struct packed {
        logic tx_ie;
        logic rx_ie;
    } ctrl_t;

endpackage

// File: rtl/uart_ctrl_fifo_fifo.sv
// Byte FIFO with power-of-two depth; a pop frees room for a same-cycle push when full.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_ctrl_fifo.sv
// UART host-side controller: register window, RX/TX byte FIFOs, interrupts and TX launcher.
// state  | meaning
// IDLE   | waiting for a queued byte while the transmitter is free
// LAUNCH | tx_start pulse with the FIFO head, head popped
// WAIT   | transmitter busy until tx_end
module uart_ctrl_fifo
    import uart_ctrl_fifo_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              as,
    input  logic              rw,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy,
    output logic              irq_rx,
    output logic              irq_tx,
    input  logic              rx_busy,
    input  logic              rx_end,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    input  logic              tx_end,
    output logic              tx_start,
    output logic [7:0]        tx_data
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic              access, rd_acc, wr_acc;
    logic              tx_push, tx_pop, rx_pop;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]        tx_dout, rx_dout;
    logic [TX_CW-1:0]  tx_count;
    logic [RX_CW-1:0]  rx_count;
    logic [DATA_W+23:0] level;
    logic              unused_bits;

    logic [1:0]        state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              rx_ovf_q, rx_ovf_d;
    logic              rdy_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              irq_rx_q, irq_rx_d, irq_tx_q, irq_tx_d;

    assign access  = !cs && !as;
    assign rd_acc  = access && rw;
    assign wr_acc  = access && !rw;
    // A full TX FIFO drops the write even if the launcher pops in the same cycle.
    assign tx_push = wr_acc && (addr == ADDR_DATA) && !tx_full;
    assign tx_pop  = (state_q == TX_LAUNCH);
    assign rx_pop  = rd_acc && (addr == ADDR_DATA) && !rx_empty;

    uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wr_data[7:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_end), .pop(rx_pop), .din(rx_data),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_comb begin
        level = '0;
        level[16 +: TX_CW] = tx_count;
        level[0 +: RX_CW]  = rx_count;
    end

    assign unused_bits = ^{wr_data[DATA_W-1:8], level[DATA_W+23:DATA_W]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:   if (!tx_empty && !tx_busy) state_d = TX_LAUNCH;
            TX_LAUNCH: state_d = TX_WAIT;
            TX_WAIT:   if (tx_end) state_d = TX_IDLE;
            default:   state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        rx_ovf_d = rx_ovf_q;
        if (wr_acc && addr == ADDR_CTRL) ctrl_d = ctrl_t'(wr_data[1:0]);
        if (wr_acc && addr == ADDR_STATUS && wr_data[ST_RX_OVF]) rx_ovf_d = 1'b0;
        // A new overflow in the clearing cycle wins over the clear.
        if (rx_end && rx_full && !rx_pop) rx_ovf_d = 1'b1;
        irq_rx_d = ctrl_q.rx_ie & (!rx_empty | rx_ovf_q);
        irq_tx_d = ctrl_q.tx_ie & tx_empty & (state_q == TX_IDLE);
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_acc) begin
            case (addr)
                ADDR_STATUS: begin
                    rd_data_d[ST_IRQ_RX]   = irq_rx_q;
                    rd_data_d[ST_IRQ_TX]   = irq_tx_q;
                    rd_data_d[ST_RX_BUSY]  = rx_busy;
                    rd_data_d[ST_TX_BUSY]  = tx_busy;
                    rd_data_d[ST_RX_EMPTY] = rx_empty;
                    rd_data_d[ST_TX_FULL]  = tx_full;
                    rd_data_d[ST_RX_OVF]   = rx_ovf_q;
                end
                ADDR_DATA:  if (!rx_empty) rd_data_d[7:0] = rx_dout;
                ADDR_CTRL:  rd_data_d[1:0] = ctrl_q;
                ADDR_LEVEL: rd_data_d = level[DATA_W-1:0];
                default:    rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            ctrl_q    <= '0;
            rx_ovf_q  <= 1'b0;
            rdy_q     <= 1'b1;
            rd_data_q <= '0;
            irq_rx_q  <= 1'b0;
            irq_tx_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            rx_ovf_q  <= rx_ovf_d;
            rdy_q     <= !access;
            rd_data_q <= rd_data_d;
            irq_rx_q  <= irq_rx_d;
            irq_tx_q  <= irq_tx_d;
        end
    end

    assign rdy      = rdy_q;
    assign rd_data  = rd_data_q;
    assign irq_rx   = irq_rx_q;
    assign irq_tx   = irq_tx_q;
    assign tx_start = (state_q == TX_LAUNCH);
    assign tx_data  = tx_start ? tx_dout : 8'h00;

endmodule

// File: tb/tb_uart_ctrl_fifo.sv
// Directed bench for uart_ctrl_fifo with a queue-based reference model checked every cycle.
module tb_uart_ctrl_fifo;
    localparam int TXD = 16;
    localparam int RXD = 16;
    localparam int DW  = 32;
    localparam logic [1:0] A_STATUS = 2'd0, A_DATA = 2'd1, A_CTRL = 2'd2, A_LEVEL = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b1, as = 1'b1, rw = 1'b0;
    logic [1:0]    addr = 2'd0;
    logic [DW-1:0] wr_data = '0;
    logic          rx_busy = 1'b0, rx_end = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          force_busy = 1'b0, resp_busy = 1'b0, tx_end = 1'b0, auto_tx = 1'b1;
    logic          tx_busy;
    logic [DW-1:0] rd_data;
    logic          rdy, irq_rx, irq_tx, tx_start;
    logic [7:0]    tx_data;

    int vectors = 0;
    int miscompares = 0;

    assign tx_busy = force_busy | resp_busy;
    always #5 clk = ~clk;

    uart_ctrl_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .cs(cs), .as(as), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rdy(rdy), .irq_rx(irq_rx), .irq_tx(irq_tx),
        .rx_busy(rx_busy), .rx_end(rx_end), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_end(tx_end), .tx_start(tx_start), .tx_data(tx_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, launcher as a three-phase channel.
    logic [7:0]  mtx[$];
    logic [7:0]  mrx[$];
    bit          movf = 0;
    logic [1:0]  mctrl = 2'b00;
    int          mphase = 0;
    logic [7:0]  mtxd = 8'h00;
    logic        e_rdy = 1'b1, e_irq_rx = 1'b0, e_irq_tx = 1'b0;
    logic [31:0] e_rd = '0;

    initial begin : model
        logic [31:0] rd;
        bit acc, rd_pop, ovf_set, nirq_rx, nirq_tx;
        int txn, rxn;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mtx.delete(); mrx.delete();
                movf = 0; mctrl = 2'b00; mphase = 0; mtxd = 8'h00;
                e_rdy = 1'b1; e_rd = '0; e_irq_rx = 1'b0; e_irq_tx = 1'b0;
            end else begin
                acc = !cs && !as;
                txn = mtx.size();
                rxn = mrx.size();
                rd  = '0;
                if (acc && rw) begin
                    case (addr)
                        A_STATUS: begin
                            rd[0] = e_irq_rx; rd[1] = e_irq_tx; rd[2] = rx_busy; rd[3] = tx_busy;
                            rd[4] = (rxn == 0); rd[5] = (txn == TXD); rd[6] = movf;
                        end
                        A_DATA:  if (rxn != 0) rd = {24'h0, mrx[0]};
                        A_CTRL:  rd = {30'h0, mctrl};
                        default: rd = (32'(txn) << 16) | 32'(rxn);
                    endcase
                end
                nirq_rx = mctrl[0] && (rxn != 0 || movf);
                nirq_tx = mctrl[1] && (txn == 0) && (mphase == 0);
                case (mphase)
                    0: if (txn != 0 && !tx_busy) begin mphase = 1; mtxd = mtx[0]; end
                    1: begin void'(mtx.pop_front()); mphase = 2; end
                    default: if (tx_end) mphase = 0;
                endcase
                if (acc && !rw && addr == A_DATA && txn < TXD) mtx.push_back(wr_data[7:0]);
                rd_pop = acc && rw && addr == A_DATA && rxn != 0;
                if (rd_pop) void'(mrx.pop_front());
                ovf_set = 0;
                if (rx_end) begin
                    if (rxn < RXD || rd_pop) mrx.push_back(rx_data);
                    else ovf_set = 1;
                end
                if (acc && !rw && addr == A_STATUS && wr_data[6]) movf = 0;
                if (ovf_set) movf = 1;
                if (acc && !rw && addr == A_CTRL) mctrl = wr_data[1:0];
                e_rdy = !acc; e_rd = rd; e_irq_rx = nirq_rx; e_irq_tx = nirq_tx;
            end
        end
    end

    initial begin : compare
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                check("rdy", rdy, e_rdy);
                check("rd_data", rd_data, e_rd);
                check("irq_rx", irq_rx, e_irq_rx);
                check("irq_tx", irq_tx, e_irq_tx);
                check("tx_start", tx_start, mphase == 1);
                check("tx_data", tx_data, (mphase == 1) ? mtxd : 8'h00);
            end
        end
    end

    logic [7:0] txlog[$];
    int starts = 0, ends = 0;

    initial begin : tx_monitor
        forever begin
            @(posedge clk);
            #2;
            if (tx_end) ends++;
            if (tx_start) begin
                if (auto_tx) check("start_after_end", starts, ends);
                starts++;
                txlog.push_back(tx_data);
            end
        end
    end

    initial begin : tx_responder
        int cnt = 0;
        forever begin
            @(negedge clk);
            tx_end = 1'b0;
            if (rst) begin
                cnt = 0; resp_busy = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin tx_end = 1'b1; resp_busy = 1'b0; end
            end else if (tx_start && auto_tx) begin
                resp_busy = 1'b1; cnt = 4;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b0; as = 1'b0; rw = 1'b0; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b1; as = 1'b1; wr_data = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b0; as = 1'b0; rw = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b1; as = 1'b1; rw = 1'b0;
        d = rd_data;
    endtask

    task automatic rx_pulse(input logic [7:0] v);
        @(negedge clk);
        rx_end = 1'b1; rx_data = v;
        @(negedge clk);
        rx_end = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k = 0;
        while (txlog.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, txlog.size(), n);
    endtask

    initial begin : stimulus
        logic [31:0] d;

        repeat (2) @(posedge clk);
        #2;
        check("reset_rdy", rdy, 1);
        check("reset_rd_data", rd_data, 0);
        check("reset_irq", {irq_rx, irq_tx}, 0);
        check("reset_tx", {tx_start, tx_data}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Three queued bytes go out in order, one per tx_end.
        bus_write(A_DATA, 32'h41);
        bus_write(A_DATA, 32'h42);
        bus_write(A_DATA, 32'h43);
        wait_log(3, 300, "tx_three_count");
        check("tx_byte0", txlog[0], 8'h41);
        check("tx_byte1", txlog[1], 8'h42);
        check("tx_byte2", txlog[2], 8'h43);
        repeat (10) @(negedge clk);

        // TX overfill while the transmitter is busy.
        txlog.delete();
        force_busy = 1'b1;
        for (int i = 0; i <= TXD; i++) bus_write(A_DATA, 32'h10 + i);
        bus_read(A_LEVEL, d);
        check("level_tx_full", d, 32'h0010_0000);
        bus_read(A_STATUS, d);
        check("status_tx_full", d, 32'h38);
        force_busy = 1'b0;
        wait_log(TXD, 400, "tx_drain_count");
        repeat (20) @(negedge clk);
        check("tx_drain_total", txlog.size(), TXD);
        check("tx_drain_first", txlog[0], 8'h10);
        check("tx_drain_last", txlog[TXD-1], 8'h1F);

        // RX overflow, drain, then clear the sticky flag.
        bus_write(A_CTRL, 32'h1);
        for (int i = 0; i <= RXD; i++) rx_pulse(8'h80 + 8'(i));
        rx_busy = 1'b1;
        bus_read(A_STATUS, d);
        rx_busy = 1'b0;
        check("status_rx_ovf", d, 32'h45);
        check("irq_rx_ovf", irq_rx, 1);
        for (int i = 0; i < RXD; i++) begin
            bus_read(A_DATA, d);
            check("rx_read_ovf", d, 32'h80 + i);
        end
        bus_write(A_STATUS, 32'h40);
        bus_read(A_STATUS, d);
        check("status_ovf_cleared", d, 32'h10);

        // Full RX FIFO with push and pop in the same cycle.
        for (int i = 0; i < RXD; i++) rx_pulse(8'hA0 + 8'(i));
        @(negedge clk);
        cs = 1'b0; as = 1'b0; rw = 1'b1; addr = A_DATA; rx_end = 1'b1; rx_data = 8'hB0;
        @(negedge clk);
        cs = 1'b1; as = 1'b1; rw = 1'b0; rx_end = 1'b0;
        check("rx_simul_read", rd_data, 32'hA0);
        bus_read(A_STATUS, d);
        check("status_simul_no_ovf", d, 32'h01);
        bus_read(A_LEVEL, d);
        check("level_simul", d, 32'h0000_0010);
        @(negedge clk);
        cs = 1'b1; as = 1'b0; rw = 1'b1; addr = A_DATA;
        @(negedge clk);
        as = 1'b1; rw = 1'b0;
        for (int i = 0; i < RXD; i++) begin
            bus_read(A_DATA, d);
            check("rx_read_simul", d, (i < RXD - 1) ? 32'hA1 + i : 32'hB0);
        end
        bus_read(A_DATA, d);
        check("rx_read_empty", d, 0);

        // TX interrupt while idle and empty.
        bus_write(A_CTRL, 32'h2);
        repeat (3) @(negedge clk);
        check("irq_tx_idle", irq_tx, 1);
        txlog.delete();
        bus_write(A_DATA, 32'h55);
        @(negedge clk);
        check("irq_tx_busy", irq_tx, 0);
        wait_log(1, 50, "tx_irq_count");
        repeat (15) @(negedge clk);
        check("irq_tx_done", irq_tx, 1);
        check("tx_irq_byte", txlog[0], 8'h55);

        // Reset in WAIT with three bytes queued.
        auto_tx = 1'b0;
        txlog.delete();
        for (int i = 0; i < 4; i++) bus_write(A_DATA, 32'h61 + i);
        repeat (2) @(negedge clk);
        check("wait_launched", txlog.size(), 1);
        check("wait_byte", txlog[0], 8'h61);
        bus_read(A_LEVEL, d);
        check("level_queued", d, 32'h0003_0000);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_rdy", rdy, 1);
        check("rst_rd_data", rd_data, 0);
        check("rst_irq", {irq_rx, irq_tx}, 0);
        check("rst_tx", {tx_start, tx_data}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_tx_after_rst", txlog.size(), 1);
        bus_read(A_LEVEL, d);
        check("level_after_rst", d, 0);
        bus_read(A_CTRL, d);
        check("ctrl_after_rst", d, 0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_ctrl_fifo.md
UART_CTRL_FIFO -- requirements
Module: uart_ctrl_fifo

Interface
REQ-001 Parameters SHALL be: TX_DEPTH, 16, TX FIFO entries, power of two, 2..256.
REQ-002 Parameters SHALL be: RX_DEPTH, 16, RX FIFO entries, power of two, 2..256.
REQ-003 Parameters SHALL be: DATA_W, 32, bus word width, at least 16.
REQ-004 Ports SHALL be:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  chip select, active-low.
- as  in  1  address strobe, active-low.
- rw  in  1  1 = read, 0 = write.
- addr  in  2  register select: 0 STATUS, 1 DATA, 2 CTRL, 3 LEVEL.
- wr_data  in  DATA_W  write data.
- rd_data  out  DATA_W  read data.
- rdy  out  1  access acknowledge, active-low.
- irq_rx  out  1  RX interrupt.
- irq_tx  out  1  TX interrupt.
- rx_busy, rx_end  in  1 each  receiver status; rx_end is a 1-cycle pulse.
- rx_data  in  8  received byte.
- tx_busy, tx_end  in  1 each  transmitter status; tx_end is a 1-cycle pulse.
- tx_start  out  1  1-cycle launch pulse.
- tx_data  out  8  byte to send, valid with tx_start.

Function
REQ-005 An access SHALL be cs=0 and as=0; rdy SHALL go low exactly one cycle after each access cycle and high otherwise.
REQ-006 rd_data SHALL be registered: the value for a read appears one cycle after the access, and is 0 in every other cycle.
REQ-007 STATUS read SHALL return {0.., rx_ovf, tx_full, rx_empty, tx_busy, rx_busy, irq_tx, irq_rx} in bits [6:0].
REQ-008 STATUS write SHALL clear rx_ovf when bit 6 is 1; all other bits are read-only.
REQ-009 DATA write SHALL push wr_data[7:0] into the TX FIFO; when the TX FIFO is full, the byte is dropped and no state changes.
REQ-010 DATA read SHALL return the RX FIFO head in bits [7:0] and pop it; on an empty FIFO it returns 0 and does not pop.
REQ-011 CTRL SHALL be read/write: bit0 rx_ie, bit1 tx_ie; reset value 0.
REQ-012 LEVEL read SHALL return {tx_count in [23:16], rx_count in [7:0]}; writes to LEVEL are ignored.
REQ-013 A push on rx_end SHALL store rx_data; when the RX FIFO is full, the byte is dropped and rx_ovf is set (sticky).
REQ-014 A simultaneous RX push and pop SHALL both take effect, with the count unchanged; a full FIFO with simultaneous pop SHALL accept the push without overflow.
REQ-015 The TX launcher FSM SHALL have three states:
- IDLE: goes to LAUNCH when the TX FIFO is non-empty and tx_busy=0.
- LAUNCH: pops the FIFO, drives tx_start=1 with tx_data for exactly one cycle, then goes to WAIT.
- WAIT: returns to IDLE on tx_end.
REQ-016 tx_data SHALL be 0 whenever tx_start is 0.
REQ-017 irq_rx SHALL be registered and equal rx_ie & (!rx_empty | rx_ovf).
REQ-018 irq_tx SHALL be registered and equal tx_ie & tx_empty & FSM==IDLE.
REQ-019 Counts SHALL be width clog2(DEPTH)+1, and FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-020 While rst=1 (asynchronous), all outputs SHALL be 0 except rdy=1; FIFOs SHALL be empty, rx_ovf=0, CTRL=0, FSM=IDLE.
REQ-021 Reset asserted mid-frame SHALL discard FIFO contents and abort the FSM without emitting tx_start.

Structure
REQ-022 Register addresses, CTRL/STATUS bit indices, and FSM state encodings SHALL live in the shared defines package.
REQ-023 Both FIFOs SHALL be instances of one sub-module, uart_fifo (parameters DEPTH, WIDTH=8; ports push, pop, din, dout, full, empty, count).

Verification
REQ-024 Verification SHALL cover these directed scenarios:
- Write 0x41, 0x42, 0x43 to DATA with tx_busy=0 -> three tx_start pulses in order 0x41, 0x42, 0x43, each issued only after the prior tx_end.
- Write TX_DEPTH+1 bytes while tx_busy=1 -> LEVEL tx_count=TX_DEPTH, last byte never transmitted.
- Apply RX_DEPTH+1 rx_end pulses -> rx_ovf=1, irq_rx=1 with rx_ie=1, reads return the first RX_DEPTH bytes, then a STATUS write of 0x40 clears rx_ovf.
- Pulse rx_end in the same cycle as a DATA read with the RX FIFO full -> no overflow, rx_count unchanged.
- Write CTRL=0x2 with TX idle and empty -> irq_tx=1; then write DATA -> irq_tx=0 until the final tx_end.
- Assert rst during the WAIT state with 3 bytes queued -> all outputs at reset values, no tx_start after release, tx_count=0.
